// File: rtl/bram_stream_loader.sv
// Byte-stream to BRAM loader: packs 4 stream bytes per word and writes consecutive words
// from C_BASEADDR. Optional read-back verify enabled by defining BRAM_LOADER_VERIFY_EN.
module bram_stream_loader #(
  parameter logic [31:0] C_BASEADDR  = 32'h0000_0000,
  parameter int          C_MEMSIZE   = 'h4000,
  parameter int          C_LEN_WIDTH = 13
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Start,
  input  logic [C_LEN_WIDTH-1:0] Num_Words,
  input  logic [7:0]             S_Data,
  input  logic                   S_Valid,
  output logic                   S_Ready,
  output logic                   BRAM_Rst,
  output logic                   BRAM_Clk,
  output logic                   BRAM_EN,
  output logic [3:0]             BRAM_WEN,
  output logic [31:0]            BRAM_Addr,
  output logic [31:0]            BRAM_Dout,
  input  logic [31:0]            BRAM_Din,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  output logic [C_LEN_WIDTH-1:0] Words_Written
);

  // Vectors are little-endian numbered: the first stream byte of a word lands in [31:24],
  // which is the big-endian lane [0:7] of the BRAM port.
  localparam logic [31:0] MAX_WORDS = 32'(C_MEMSIZE / 4);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COLLECT    = 3'd1,
    WRITE      = 3'd2,
    VERIFY_RD  = 3'd3,
    VERIFY_CMP = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [31:0]            addr;
  logic [31:0]            word;
  logic [1:0]             byte_cnt;
  logic [C_LEN_WIDTH-1:0] num_words;
  logic [C_LEN_WIDTH-1:0] words_written;
  logic                   error;

  logic                   len_zero;
  logic                   range_err;
  logic [C_LEN_WIDTH-1:0] ww_inc;
  logic                   last_word;

  assign len_zero  = (Num_Words == '0);
  assign range_err = (32'(Num_Words) > MAX_WORDS);
  assign ww_inc    = words_written + C_LEN_WIDTH'(1);
  assign last_word = (ww_inc == num_words);

  assign BRAM_Rst      = ~Rst_n;
  assign BRAM_Clk      = Clk;
  assign BRAM_Addr     = addr;
  assign BRAM_Dout     = word;
  assign Error         = error;
  assign Words_Written = words_written;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) begin
          if (len_zero || range_err) state_nxt = DONE;
          else                       state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (S_Valid && (byte_cnt == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
`ifdef BRAM_LOADER_VERIFY_EN
        state_nxt = VERIFY_RD;
`else
        state_nxt = last_word ? DONE : COLLECT;
`endif
      end
      VERIFY_RD:  state_nxt = VERIFY_CMP;
      // words_written was already bumped in WRITE, so equality means this was the last word
      VERIFY_CMP: state_nxt = (words_written == num_words) ? DONE : COLLECT;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    S_Ready  = (state == COLLECT);
    BRAM_EN  = (state == WRITE) || (state == VERIFY_RD);
    BRAM_WEN = (state == WRITE) ? 4'b1111 : 4'b0000;
    Busy     = (state == COLLECT) || (state == WRITE) ||
               (state == VERIFY_RD) || (state == VERIFY_CMP);
    Done     = (state == DONE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr          <= '0;
      word          <= '0;
      byte_cnt      <= '0;
      num_words     <= '0;
      words_written <= '0;
      error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            num_words     <= Num_Words;
            words_written <= '0;
            byte_cnt      <= '0;
            addr          <= C_BASEADDR;
            error         <= range_err;
          end
        end
        COLLECT: begin
          if (S_Valid) begin
            word     <= {word[23:0], S_Data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          words_written <= ww_inc;
`ifndef BRAM_LOADER_VERIFY_EN
          // Address is held on the last word so it never points past the loaded region
          if (!last_word) addr <= addr + 32'd4;
`endif
        end
`ifdef BRAM_LOADER_VERIFY_EN
        VERIFY_CMP: begin
          if (BRAM_Din != word) error <= 1'b1;
          if (words_written != num_words) addr <= addr + 32'd4;
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef BRAM_LOADER_VERIFY_EN
  logic unused_din;
  assign unused_din = ^BRAM_Din;
`endif

endmodule
